// File: rtl/hazard_pkg.sv
// Shared types for the EX-stage hazard controller: forwarding selects,
// shadow pipeline slots and the multiply sequencer states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  // X31 reads as zero and is never a real forwarding source
  localparam logic [4:0] REG_ZR = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       uses_rn;
    logic       uses_rm;
    logic       reg_write;
    logic       mem_read;
    logic       set_flags;
    logic       is_mul;
  } ex_slot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } wb_slot_t;

  typedef enum logic {
    IDLE,
    BUSY
  } mul_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding source for one EX operand; the MEM ALU result beats the WB result.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       used,
  input  mem_slot_t  mem,
  input  wb_slot_t   wb,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_REG;
    if (used && (src != REG_ZR)) begin
      // a load in MEM has no ALU result yet; load-use stalls cover that case
      if (mem.valid && mem.reg_write && !mem.mem_read && (mem.rd == src)) begin
        sel = FWD_MEM;
      end else if (wb.valid && wb.reg_write && (wb.rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadow EX/MEM/WB slots drive forwarding, flag
// write enable, load-use / flag stalls and multi-cycle multiply holds.
module ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_ID,
  input  logic [4:0] Rn_ID,
  input  logic [4:0] Rm_ID,
  input  logic [4:0] Rd_ID,
  input  logic       usesRn_ID,
  input  logic       usesRm_ID,
  input  logic       regWrite_ID,
  input  logic       memRead_ID,
  input  logic       setFlags_ID,
  input  logic       isMul_ID,
  input  logic       bcond_ID,
  input  logic       flush_ID,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB,
  output logic       enable_EX,
  output logic       stall_ID,
  output logic       bubble_EX,
  output logic       hold_EX,
  output logic       mul_start
);

  localparam int unsigned CntW = $clog2(MUL_LAT + 1);

  ex_slot_t          ex_q, ex_d;
  mem_slot_t         mem_q;
  wb_slot_t          wb_q;
  mul_state_t        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              flush_q;

  logic     mul_in_ex, hold, rn_hit, rm_hit, load_use, flag_use, kill;
  fwd_sel_t fwd_a, fwd_b;

  assign mul_in_ex = ex_q.valid & ex_q.is_mul;
  assign hold      = (state_q == IDLE) ? (mul_in_ex && (MUL_LAT > 1)) : (cnt_q > CntW'(1));

  assign rn_hit   = usesRn_ID && (Rn_ID == ex_q.rd);
  assign rm_hit   = usesRm_ID && (Rm_ID == ex_q.rd);
  assign load_use = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd != REG_ZR) &
                    (rn_hit | rm_hit);
  assign flag_use = valid_ID & bcond_ID & ex_q.valid & ex_q.set_flags;
  // a flush seen during a hold is replayed on the first cycle ID/EX loads again
  assign kill     = flush_ID | flush_q;

  assign hold_EX   = hold;
  assign mul_start = (state_q == IDLE) & mul_in_ex;
  assign enable_EX = ex_q.valid & ex_q.set_flags & ~hold;
  assign stall_ID  = ~reset & (hold | (~kill & (load_use | flag_use)));
  assign bubble_EX = ~reset & ~hold & (kill | load_use | flag_use);
  assign forwardA  = fwd_a;
  assign forwardB  = fwd_b;

  fwd_select u_fwd_a (
    .src  (ex_q.rn),
    .used (ex_q.valid & ex_q.uses_rn),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (fwd_a)
  );

  fwd_select u_fwd_b (
    .src  (ex_q.rm),
    .used (ex_q.valid & ex_q.uses_rm),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (fwd_b)
  );

  always_comb begin
    ex_d = '0;
    if (valid_ID && !kill && !load_use && !flag_use) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = Rd_ID;
      ex_d.rn        = Rn_ID;
      ex_d.rm        = Rm_ID;
      ex_d.uses_rn   = usesRn_ID;
      ex_d.uses_rm   = usesRm_ID;
      ex_d.reg_write = regWrite_ID;
      ex_d.mem_read  = memRead_ID;
      ex_d.set_flags = setFlags_ID;
      ex_d.is_mul    = isMul_ID;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      wb_q.valid     <= mem_q.valid;
      wb_q.rd        <= mem_q.rd;
      wb_q.reg_write <= mem_q.reg_write;
      if (hold) begin
        mem_q   <= '0;
        flush_q <= flush_q | flush_ID;
      end else begin
        mem_q.valid     <= ex_q.valid;
        mem_q.rd        <= ex_q.rd;
        mem_q.reg_write <= ex_q.reg_write;
        mem_q.mem_read  <= ex_q.mem_read;
        flush_q         <= 1'b0;
        ex_q            <= ex_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mul_in_ex && (MUL_LAT > 1)) begin
            state_q <= BUSY;
            cnt_q   <= CntW'(MUL_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

endmodule
